// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and widths for the fetch sequencer.
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t;
    localparam int PC_WIDTH_DEF = 12;
    localparam int LUT_IDX_W = 4;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control, lookup-table and status signals around the PC sequencer.
interface pc_sequencer_if import cpu_pkg::*; #(
    parameter int PC_width  = PC_WIDTH_DEF,
    parameter int CNT_width = 16
);
    logic                 start;
    logic [PC_width-1:0]  start_addr;
    logic                 stall;
    logic                 halt;
    logic                 jump_en;
    logic                 branch_en;
    logic                 rel_mode;
    logic [LUT_IDX_W-1:0] lut_sel;
    logic [LUT_IDX_W-1:0] lut_addr;
    logic [PC_width-1:0]  lut_data;
    logic [PC_width-1:0]  pc;
    logic                 running;
    logic                 done;
    logic                 redirect;
    logic [CNT_width-1:0] instr_count;
    modport slave (
        input  start, start_addr, stall, halt, jump_en, branch_en, rel_mode, lut_sel, lut_data,
        output lut_addr, pc, running, done, redirect, instr_count
    );
    modport master (
        output start, start_addr, stall, halt, jump_en, branch_en, rel_mode, lut_sel, lut_data,
        input  lut_addr, pc, running, done, redirect, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, sequences fetch through IDLE/RUN/HALT and counts retired instructions.
module pc_sequencer import cpu_pkg::*; #(
    parameter int PC_width  = PC_WIDTH_DEF,
    parameter int CNT_width = 16
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    seq_state_t           state_q, state_d;
    logic [PC_width-1:0]  pc_q, pc_d, target;
    logic [CNT_width-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 redirect_q, redirect_d, take;

    assign bus.lut_addr    = bus.lut_sel;
    assign bus.pc          = pc_q;
    assign bus.running     = state_q == RUN;
    assign bus.done        = state_q == HALT;
    assign bus.redirect    = redirect_q;
    assign bus.instr_count = cnt_q;

    assign take    = bus.jump_en | bus.branch_en;
    assign target  = bus.rel_mode ? pc_q + bus.lut_data : bus.lut_data;
    // Retire count sticks at all-ones rather than wrapping.
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_width'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        if (bus.start) begin
            state_d = RUN;
            pc_d    = bus.start_addr;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            if (bus.halt) begin
                state_d = HALT;
                cnt_d   = cnt_inc;
            end else if (!bus.stall) begin
                cnt_d      = cnt_inc;
                pc_d       = take ? target : pc_q + PC_width'(1);
                redirect_d = take;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a rule-level model.
module tb_pc_sequencer;
    localparam int PCM = 4096;
    localparam int CMAX = 65535;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [11:0] lut_tbl [16];
    int m_pc, m_cnt;
    bit m_run, m_done, m_redir;

    pc_sequencer_if #(.PC_width(12), .CNT_width(16)) bus ();
    pc_sequencer_if #(.PC_width(12), .CNT_width(3)) bus2 ();

    pc_sequencer #(.PC_width(12), .CNT_width(16)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    pc_sequencer #(.PC_width(12), .CNT_width(3)) dut_sat (.Clk(Clk), .Reset(Reset), .bus(bus2));

    assign bus.lut_data  = lut_tbl[bus.lut_addr];
    assign bus2.lut_data = 12'h000;

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("pc", bus.pc, m_pc);
        chk("running", bus.running, m_run);
        chk("done", bus.done, m_done);
        chk("redirect", bus.redirect, m_redir);
        chk("instr_count", bus.instr_count, m_cnt);
    endtask

    function automatic int retire(input int c);
        return c < CMAX ? c + 1 : c;
    endfunction

    task automatic model();
        int tgt;
        tgt = bus.rel_mode ? (m_pc + int'(lut_tbl[bus.lut_sel])) % PCM : int'(lut_tbl[bus.lut_sel]);
        m_redir = 0;
        if (Reset) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        end else if (bus.start) begin
            m_run = 1; m_done = 0; m_pc = int'(bus.start_addr); m_cnt = 0;
        end else if (m_run) begin
            if (bus.halt) begin
                m_run = 0; m_done = 1; m_cnt = retire(m_cnt);
            end else if (!bus.stall) begin
                m_cnt = retire(m_cnt);
                if (bus.jump_en || bus.branch_en) begin
                    m_pc = tgt; m_redir = 1;
                end else m_pc = (m_pc + 1) % PCM;
            end
        end
    endtask

    task automatic drive(input bit st, input logic [11:0] sa, input bit stl, input bit h,
                         input bit j, input bit b, input bit r, input logic [3:0] sel);
        bus.start = st; bus.start_addr = sa; bus.stall = stl; bus.halt = h;
        bus.jump_en = j; bus.branch_en = b; bus.rel_mode = r; bus.lut_sel = sel;
    endtask

    task automatic step();
        chk("lut_addr", bus.lut_addr, bus.lut_sel);
        @(posedge Clk);
        model();
        #1 chk_all();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut_tbl[i] = 12'(i);
        lut_tbl[4] = 12'h00B;
        lut_tbl[5] = 12'hFFC;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus2.start = 0; bus2.start_addr = 0; bus2.stall = 0; bus2.halt = 0;
        bus2.jump_en = 0; bus2.branch_en = 0; bus2.rel_mode = 0; bus2.lut_sel = 0;
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_redir = 0;
        #2 chk_all();
        @(negedge Clk) Reset = 1'b0;
        // start and plain sequencing
        drive(1, 12'h010, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        // absolute jump, one-cycle redirect
        drive(1, 12'h005, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0, 0, 4); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // relative branch backwards, then increment wrap
        drive(1, 12'h008, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 1, 5); step();
        drive(1, 12'hFFF, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // jump and branch together redirect once, relative default entry falls through
        drive(0, 0, 0, 0, 1, 1, 1, 1); step();
        // stall beats jump
        drive(1, 12'h020, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, 1, 0, 0, 4); repeat (2) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // halt after 7 retired, hold, restart
        drive(1, 12'h029, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (7) step();
        drive(0, 0, 1, 1, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 1, 1, 1, 4); step();
        drive(0, 0, 0, 0, 1, 0, 0, 4); repeat (4) step();
        drive(1, 12'h000, 0, 0, 0, 0, 0, 0); step();
        // async reset between edges at pc 'h044
        drive(1, 12'h040, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (4) step();
        #2 Reset = 1'b1;
        m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_redir = 0;
        #1 chk_all();
        drive(1, 12'h123, 0, 0, 0, 0, 0, 0); step();
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        // randomized traffic
        for (int i = 0; i < 16; i++) lut_tbl[i] = 12'($urandom);
        lut_tbl[1] = 12'h001;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(15) == 0, 12'($urandom), $urandom_range(3) == 0,
                  $urandom_range(15) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                  1'($urandom), 4'($urandom));
            step();
        end
        // counter saturation on a narrow-count instance
        bus2.start = 1; bus2.start_addr = 12'hFFA;
        @(posedge Clk); #1 bus2.start = 0;
        repeat (10) @(posedge Clk);
        #1;
        chk("sat_count", bus2.instr_count, 7);
        chk("sat_pc", bus2.pc, 12'h004);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
